// File: rtl/mips32_mem_dumper_pkg.sv
// Shared types and constants for the mips32 memory dumper: state encodings, widths, byte-lane select.
// Pure definitions: no latency and no backpressure of its own.
package mips32_mem_dumper_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 9;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4
    } dump_state_t;

    // Byte lane 0 is the most significant byte of the word.
    function automatic logic [7:0] msb_first_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] sel;
        case (idx)
            2'd0:    sel = word[31:24];
            2'd1:    sel = word[23:16];
            2'd2:    sel = word[15:8];
            default: sel = word[7:0];
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mips32_mem_dumper_if.sv
// Control, memory read port and byte stream of the dumper; master = dumper, slave = memory/sink side.
// Pure wiring: zero latency; the byte stream is valid/ready.
interface mips32_mem_dumper_if #(
    parameter int ADDR_WIDTH = mips32_mem_dumper_pkg::DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = mips32_mem_dumper_pkg::DEF_CNT_WIDTH
) ();
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [CNT_WIDTH-1:0]  i_word_count;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [31:0]           i_mem_rd_data;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        input  i_start, i_base_addr, i_word_count, i_mem_rd_data, i_tx_ready,
        output o_mem_addr, o_tx_data, o_tx_valid, o_busy, o_done
    );

    modport slave (
        output i_start, i_base_addr, i_word_count, i_mem_rd_data, i_tx_ready,
        input  o_mem_addr, o_tx_data, o_tx_valid, o_busy, o_done
    );
endinterface

// File: rtl/mips32_mem_dumper_word_serializer.sv
// Holds one fetched word and presents it a byte at a time, MSB first; load takes effect next cycle.
// The byte index only moves on i_advance, so the presented byte is stable under backpressure.
module mips32_word_serializer
    import mips32_mem_dumper_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_advance,
    output logic [7:0]  o_byte,
    output logic        o_last_byte
);
    logic [31:0] r_word;
    logic [1:0]  r_byte_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word     <= '0;
            r_byte_idx <= '0;
        end else if (i_clear) begin
            r_byte_idx <= '0;
        end else if (i_load) begin
            r_word     <= i_word;
            r_byte_idx <= '0;
        end else if (i_advance) begin
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

    assign o_byte      = msb_first_byte(r_word, r_byte_idx);
    assign o_last_byte = (r_byte_idx == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/mips32_mem_dumper.sv
// Walks word_count memory words from base_addr and streams them MSB first; 1 FETCH + 4 SEND cycles per word.
// Each stalled tx_ready cycle adds one cycle; optional XOR trailer byte under MIPS32_DUMP_CHECKSUM_EN.
module mips32_mem_dumper
    import mips32_mem_dumper_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    mips32_mem_dumper_if.master   bus
);
`ifdef MIPS32_DUMP_CHECKSUM_EN
    localparam dump_state_t ST_TAIL = ST_CSUM;
    logic [7:0] r_csum;
`else
    localparam dump_state_t ST_TAIL = ST_DONE;
`endif

    dump_state_t           r_state;
    dump_state_t           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_word_idx;
    logic                  w_start_acc;
    logic                  w_more_words;
    logic                  w_xfer;
    logic                  w_advance;
    logic                  w_last_byte;
    logic [7:0]            w_ser_byte;
    logic                  w_tx_valid;
    logic [7:0]            w_tx_data;

    assign w_start_acc  = (r_state == ST_IDLE) && bus.i_start;
    assign w_more_words = (r_word_idx + CNT_WIDTH'(1)) < r_count;
    assign w_xfer       = w_tx_valid && bus.i_tx_ready;
    assign w_advance    = (r_state == ST_SEND) && w_xfer;

    mips32_word_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_acc),
        .i_load      (r_state == ST_FETCH),
        .i_word      (bus.i_mem_rd_data),
        .i_advance   (w_advance),
        .o_byte      (w_ser_byte),
        .o_last_byte (w_last_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_valid  = 1'b0;
        w_tx_data   = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_state_nxt = (bus.i_word_count == '0) ? ST_TAIL : ST_FETCH;
                end
            end
            ST_FETCH: w_state_nxt = ST_SEND;
            ST_SEND: begin
                w_tx_valid = 1'b1;
                w_tx_data  = w_ser_byte;
                if (w_xfer && w_last_byte) begin
                    w_state_nxt = w_more_words ? ST_FETCH : ST_TAIL;
                end
            end
`ifdef MIPS32_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_csum;
                if (bus.i_tx_ready) begin
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // mem_addr only moves on entry to FETCH, so it holds its value everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr <= '0;
            r_count    <= '0;
            r_word_idx <= '0;
        end else if (w_start_acc) begin
            r_count    <= bus.i_word_count;
            r_word_idx <= '0;
            if (bus.i_word_count != '0) begin
                r_mem_addr <= bus.i_base_addr;
            end
        end else if (w_advance && w_last_byte && w_more_words) begin
            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
            r_word_idx <= r_word_idx + CNT_WIDTH'(1);
        end
    end

`ifdef MIPS32_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= 8'h00;
        end else if (w_start_acc) begin
            r_csum <= 8'h00;
        end else if (w_advance) begin
            r_csum <= r_csum ^ w_ser_byte;
        end
    end
`endif

    assign bus.o_mem_addr = r_mem_addr;
    assign bus.o_tx_valid = w_tx_valid;
    assign bus.o_tx_data  = w_tx_data;
    assign bus.o_busy     = (r_state != ST_IDLE);
    assign bus.o_done     = (r_state == ST_DONE);
endmodule

// File: tb/tb_mips32_mem_dumper.sv
// Directed bench for mips32_mem_dumper: stream content, cycle timing, stalls, wrap, ignored starts, async reset.
module tb_mips32_mem_dumper;
    localparam int AW = 8;
    localparam int CW = 9;
`ifdef MIPS32_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips32_mem_dumper_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    logic [31:0] mem [0:255];
    assign bus.i_mem_rd_data = mem[bus.o_mem_addr];

    mips32_mem_dumper #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    logic [7:0] addr_q[$];
    int first_valid_c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then observe each cycle (c = cycles after the start edge) until done.
    task automatic run_dump(input int max_c, input int st_s, input int st_l, input int poke_c,
                            output int done_c);
        logic       pv;
        logic [7:0] pd;
        pv = 1'b0;
        pd = 8'h00;
        done_c = -1;
        first_valid_c = -1;
        rx.delete();
        addr_q.delete();
        bus.i_tx_ready = 1'b1;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            bus.i_tx_ready = !(c >= st_s && c < st_s + st_l);
            bus.i_start = (c == poke_c);
            if (pv) begin
                check("stall_valid_held", bus.o_tx_valid, 1);
                check("stall_data_held", bus.o_tx_data, pd);
            end
            if (bus.o_tx_valid && first_valid_c < 0) first_valid_c = c;
            if (bus.o_busy && !bus.o_tx_valid && !bus.o_done) addr_q.push_back(bus.o_mem_addr);
            if (bus.o_tx_valid && bus.i_tx_ready) rx.push_back(bus.o_tx_data);
            pv = bus.o_tx_valid && !bus.i_tx_ready;
            pd = bus.o_tx_data;
            if (bus.o_done) done_c = c;
            tick();
            bus.i_start = 1'b0;
            if (done_c >= 0) break;
        end
        bus.i_tx_ready = 1'b1;
        check("done_seen", (done_c >= 0), 1);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx.size()) check({tag, "_byte"}, rx[i], exp_q[i]);
        end
    endtask

    task automatic set_deadbeef_exp();
        exp_q.delete();
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        if (CS == 1) exp_q.push_back(8'h22);
    endtask

    int dc;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'hFF] = 32'h01020304;
        mem[8'h00] = 32'hA0B0C0D0;
        bus.i_start = 1'b0;
        bus.i_base_addr = '0;
        bus.i_word_count = '0;
        bus.i_tx_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_mem_addr", bus.o_mem_addr, 0);
        check("rst_tx_data", bus.o_tx_data, 0);
        check("rst_tx_valid", bus.o_tx_valid, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single word; a start coincident with done must be ignored.
        bus.i_base_addr = 8'h10;
        bus.i_word_count = 9'd1;
        run_dump(40, 0, 0, 6 + CS, dc);
        set_deadbeef_exp();
        compare_stream("w1");
        check("w1_first_valid_cycle", first_valid_c, 2);
        check("w1_done_cycle", dc, 6 + CS);
        check("w1_fetch_count", addr_q.size(), 1);
        if (addr_q.size() > 0) check("w1_mem_addr", addr_q[0], 8'h10);
        check("w1_idle_after_done", bus.o_busy, 0);
        check("w1_mem_addr_hold", bus.o_mem_addr, 8'h10);
        tick();

        // Address wrap across the top of memory.
        bus.i_base_addr = 8'hFF;
        bus.i_word_count = 9'd2;
        run_dump(60, 0, 0, -1, dc);
        exp_q.delete();
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hB0); exp_q.push_back(8'hC0); exp_q.push_back(8'hD0);
        if (CS == 1) exp_q.push_back(8'h04);
        compare_stream("wrap");
        check("wrap_done_cycle", dc, 11 + CS);
        check("wrap_fetch_count", addr_q.size(), 2);
        if (addr_q.size() > 1) begin
            check("wrap_addr0", addr_q[0], 8'hFF);
            check("wrap_addr1", addr_q[1], 8'h00);
        end
        tick();

        // Three-cycle stall while byte 1 is presented.
        bus.i_base_addr = 8'h10;
        bus.i_word_count = 9'd1;
        run_dump(60, 3, 3, -1, dc);
        set_deadbeef_exp();
        compare_stream("stall");
        check("stall_done_cycle", dc, 9 + CS);
        tick();

        // Zero-length dump.
        bus.i_base_addr = 8'h40;
        bus.i_word_count = 9'd0;
        run_dump(20, 0, 0, -1, dc);
        exp_q.delete();
        if (CS == 1) exp_q.push_back(8'h00);
        compare_stream("zero");
        check("zero_done_cycle", dc, 1 + CS);
        check("zero_mem_addr_hold", bus.o_mem_addr, 8'h10);
        tick();

        // Start pulsed during SEND is ignored.
        bus.i_base_addr = 8'h10;
        bus.i_word_count = 9'd1;
        run_dump(40, 0, 0, 3, dc);
        set_deadbeef_exp();
        compare_stream("restart");
        check("restart_done_cycle", dc, 6 + CS);
        tick();

        // Asynchronous reset in the middle of SEND.
        bus.i_base_addr = 8'hFF;
        bus.i_word_count = 9'd2;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick(); tick();
        check("pre_rst_valid", bus.o_tx_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.o_tx_valid, 0);
        check("mid_rst_busy", bus.o_busy, 0);
        check("mid_rst_done", bus.o_done, 0);
        check("mid_rst_mem_addr", bus.o_mem_addr, 0);
        check("mid_rst_tx_data", bus.o_tx_data, 0);
        tick();
        rst = 1'b0;
        tick();
        bus.i_base_addr = 8'h10;
        bus.i_word_count = 9'd1;
        run_dump(40, 0, 0, -1, dc);
        set_deadbeef_exp();
        compare_stream("post_rst");
        check("post_rst_done_cycle", dc, 6 + CS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
